// File: rtl/clock_ctrl_if.sv
// Button inputs and counter-chain control outputs of the digital-clock front-end.
// The slave side is the controller; the master side is the button/counter environment.
interface clock_ctrl_if;
  logic       BTN_MODE;
  logic       BTN_INC;
  logic       BTN_CLR;
  logic       EN_SEC;
  logic       INC_SEC;
  logic       INC_MIN;
  logic       INC_HOUR;
  logic       CLR;
  logic [1:0] MODE;
  logic       BLINK;

  modport master (
    output BTN_MODE, BTN_INC, BTN_CLR,
    input  EN_SEC, INC_SEC, INC_MIN, INC_HOUR, CLR, MODE, BLINK
  );

  modport slave (
    input  BTN_MODE, BTN_INC, BTN_CLR,
    output EN_SEC, INC_SEC, INC_MIN, INC_HOUR, CLR, MODE, BLINK
  );
endinterface

// File: rtl/clock_ctrl.sv
// Digital-clock control front-end: 1 Hz prescaler, three debounced buttons and
// the RUN/SET mode FSM that steers increment and clear pulses to the counter chain.
module clock_ctrl #(
  parameter int DIV    = 50000000,
  parameter int DB_CYC = 400000
) (
  input  logic        CLK,
  input  logic        RST,
  clock_ctrl_if.slave bus
);
  localparam int PW = $clog2(DIV);
  localparam int HW = $clog2(DIV / 2);
  localparam int DW = $clog2(DB_CYC);

  localparam logic [PW-1:0] PRE_ZERO  = {PW{1'b0}};
  localparam logic [PW-1:0] PRE_ONE   = PW'(1);
  localparam logic [PW-1:0] PRE_MAX   = PW'(DIV - 1);
  localparam logic [HW-1:0] HALF_ZERO = {HW{1'b0}};
  localparam logic [HW-1:0] HALF_ONE  = HW'(1);
  localparam logic [HW-1:0] HALF_MAX  = HW'(DIV / 2 - 1);
  localparam logic [DW-1:0] DB_ZERO   = {DW{1'b0}};
  localparam logic [DW-1:0] DB_ONE    = DW'(1);
  localparam logic [DW-1:0] DB_MAX    = DW'(DB_CYC - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } mode_t;

  // Button vectors are indexed 0 = mode, 1 = inc, 2 = clr.
  logic [2:0]    raw_s;
  logic [2:0]    s1_r;
  logic [2:0]    s2_r;
  logic [2:0]    db_r;
  logic [2:0]    db_prev_r;
  logic [2:0]    press_r;
  logic [DW-1:0] db_cnt_r [3];

  logic          press_mode_s;
  logic          press_inc_s;
  logic          press_clr_s;

  mode_t         mode_r;
  logic [PW-1:0] presc_r;
  logic [HW-1:0] half_cnt_r;
  logic          en_sec_r;
  logic          inc_sec_r;
  logic          inc_min_r;
  logic          inc_hour_r;
  logic          clr_r;
  logic          blink_r;

  assign raw_s        = {bus.BTN_CLR, bus.BTN_INC, bus.BTN_MODE};
  assign press_mode_s = press_r[0];
  assign press_inc_s  = press_r[1];
  assign press_clr_s  = press_r[2];

  // Synchronise, debounce and edge-detect the three raw buttons.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_r      <= 3'b000;
      s2_r      <= 3'b000;
      db_r      <= 3'b000;
      db_prev_r <= 3'b000;
      press_r   <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        db_cnt_r[i] <= DB_ZERO;
      end
    end else begin
      s1_r      <= raw_s;
      s2_r      <= s1_r;
      db_prev_r <= db_r;
      press_r   <= db_r & ~db_prev_r;
      for (int i = 0; i < 3; i++) begin
        if (s2_r[i] == db_r[i]) begin
          db_cnt_r[i] <= DB_ZERO;
        end else if (db_cnt_r[i] == DB_MAX) begin
          db_r[i]     <= s2_r[i];
          db_cnt_r[i] <= DB_ZERO;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
        end
      end
    end
  end

  // Mode FSM with registered pulse outputs, 1 Hz prescaler and blink generator.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_r     <= RUN;
      presc_r    <= PRE_ZERO;
      half_cnt_r <= HALF_ZERO;
      en_sec_r   <= 1'b0;
      inc_sec_r  <= 1'b0;
      inc_min_r  <= 1'b0;
      inc_hour_r <= 1'b0;
      clr_r      <= 1'b0;
      blink_r    <= 1'b0;
    end else begin
      en_sec_r   <= 1'b0;
      inc_sec_r  <= 1'b0;
      inc_min_r  <= 1'b0;
      inc_hour_r <= 1'b0;
      clr_r      <= press_clr_s;

      // A mode press swallows a same-cycle inc; a clear press does too.
      if (press_mode_s) begin
        case (mode_r)
          RUN:      mode_r <= SET_HOUR;
          SET_HOUR: mode_r <= SET_MIN;
          SET_MIN:  mode_r <= SET_SEC;
          default:  mode_r <= RUN;
        endcase
      end else if (press_inc_s && !press_clr_s) begin
        case (mode_r)
          SET_HOUR: inc_hour_r <= 1'b1;
          SET_MIN:  inc_min_r  <= 1'b1;
          SET_SEC:  inc_sec_r  <= 1'b1;
          default:  inc_hour_r <= 1'b0;
        endcase
      end else begin
        mode_r <= mode_r;
      end

      // Counting also stops on the edge that leaves RUN, so no tick lands in a SET mode.
      if (press_clr_s || press_mode_s || (mode_r != RUN)) begin
        presc_r <= PRE_ZERO;
      end else if (presc_r == PRE_MAX) begin
        presc_r  <= PRE_ZERO;
        en_sec_r <= 1'b1;
      end else begin
        presc_r <= presc_r + PRE_ONE;
      end

      if (press_mode_s) begin
        half_cnt_r <= HALF_ZERO;
        blink_r    <= (mode_r != SET_SEC);
      end else if (mode_r == RUN) begin
        half_cnt_r <= HALF_ZERO;
        blink_r    <= 1'b0;
      end else if (half_cnt_r == HALF_MAX) begin
        half_cnt_r <= HALF_ZERO;
        blink_r    <= ~blink_r;
      end else begin
        half_cnt_r <= half_cnt_r + HALF_ONE;
      end
    end
  end

  assign bus.EN_SEC   = en_sec_r;
  assign bus.INC_SEC  = inc_sec_r;
  assign bus.INC_MIN  = inc_min_r;
  assign bus.INC_HOUR = inc_hour_r;
  assign bus.CLR      = clr_r;
  assign bus.MODE     = mode_r;
  assign bus.BLINK    = blink_r;
endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl: segment table, directed corner sequences and
// randomized buttons, all compared every cycle against a behavioural model.
module tb_clock_ctrl;
  localparam int DIV = 10;
  localparam int DB  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clock_ctrl_if bus ();

  clock_ctrl #(.DIV(DIV), .DB_CYC(DB)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int n_en, n_is, n_im, n_ih, n_clr;

  // Behavioural model state.
  logic [2:0] dl1, dl2, db, dbh, pq;
  logic [2:0] sq[$];
  int         m_mode, run_cnt, since;
  logic [7:0] exp_vec;

  typedef struct {
    logic m, i, c;
    int   cyc;
    int   e_mode, e_ih, e_im, e_is, e_clr, e_en;
  } seg_t;
  seg_t tbl[$];

  function automatic seg_t mk(logic m, logic i, logic c, int cyc, int e_mode,
                              int e_ih, int e_im, int e_is, int e_clr, int e_en);
    seg_t s;
    s.m = m; s.i = i; s.c = c; s.cyc = cyc; s.e_mode = e_mode;
    s.e_ih = e_ih; s.e_im = e_im; s.e_is = e_is; s.e_clr = e_clr; s.e_en = e_en;
    return s;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One clock edge of the model: a level is accepted after DB consecutive
  // synchronised samples disagree with it; actions lag the accepted edge by two cycles.
  task automatic model_step();
    logic [2:0] raw, u, act;
    logic       all_diff;
    logic       e_en, e_is, e_im, e_ih, e_clr, e_blink;
    int         pre;
    raw = {bus.BTN_CLR, bus.BTN_INC, bus.BTN_MODE};
    if (rst) begin
      dl1 = 3'b000; dl2 = 3'b000; db = 3'b000; dbh = 3'b000; pq = 3'b000;
      sq.delete();
      m_mode = 0; run_cnt = 0; since = 0;
      exp_vec = 8'h00;
      return;
    end
    u   = dl2;
    dl2 = dl1;
    dl1 = raw;
    act = pq;
    pq  = db & ~dbh;
    dbh = db;
    sq.push_back(u);
    if (sq.size() > DB) void'(sq.pop_front());
    if (sq.size() == DB) begin
      for (int b = 0; b < 3; b++) begin
        all_diff = 1'b1;
        foreach (sq[j]) if (sq[j][b] == db[b]) all_diff = 1'b0;
        if (all_diff) db[b] = ~db[b];
      end
    end
    e_en = 1'b0; e_is = 1'b0; e_im = 1'b0; e_ih = 1'b0;
    e_clr = act[2];
    pre = m_mode;
    if (act[0]) m_mode = (m_mode + 1) % 4;
    else if (act[1] && !act[2]) begin
      if (pre == 1) e_ih = 1'b1;
      if (pre == 2) e_im = 1'b1;
      if (pre == 3) e_is = 1'b1;
    end
    if (pre == 0 && !act[0] && !act[2]) begin
      run_cnt++;
      e_en = (run_cnt % DIV == 0);
    end else begin
      run_cnt = 0;
    end
    if (act[0]) since = 0;
    else since++;
    e_blink = (m_mode != 0) && (((since / (DIV / 2)) % 2) == 0);
    exp_vec = {e_en, e_is, e_im, e_ih, e_clr, 2'(m_mode), e_blink};
  endtask

  task automatic tick();
    logic [7:0] got;
    @(posedge clk);
    model_step();
    #1;
    got = {bus.EN_SEC, bus.INC_SEC, bus.INC_MIN, bus.INC_HOUR, bus.CLR, bus.MODE, bus.BLINK};
    check("outs", int'(got), int'(exp_vec));
    n_en  += int'(bus.EN_SEC);
    n_is  += int'(bus.INC_SEC);
    n_im  += int'(bus.INC_MIN);
    n_ih  += int'(bus.INC_HOUR);
    n_clr += int'(bus.CLR);
  endtask

  task automatic hold(int n);
    repeat (n) tick();
  endtask

  task automatic btns(logic m, logic i, logic c);
    bus.BTN_MODE = m;
    bus.BTN_INC  = i;
    bus.BTN_CLR  = c;
  endtask

  task automatic press(logic m, logic i, logic c);
    btns(m, i, c);
    hold(8);
    btns(1'b0, 1'b0, 1'b0);
    hold(8);
  endtask

  task automatic zero_cnts();
    n_en = 0; n_is = 0; n_im = 0; n_ih = 0; n_clr = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hold(2);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    btns(1'b0, 1'b0, 1'b0);
    zero_cnts();

    // mode, inc, clr, cycles, final MODE, INC_HOUR/MIN/SEC, CLR, EN_SEC (-1: model only)
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 35, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0,  8, 1, 0, 0, 0, 0, -1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0,  8, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0,  8, 2, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0,  8, 2, 0, 0, 0, 0, 0));
    for (int k = 0; k < 5; k++) begin
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8, 2, 0, 1, 0, 0, 0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8, 2, 0, 0, 0, 0, 0));
    end
    tbl.push_back(mk(1'b1, 1'b0, 1'b0,  8, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0,  8, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0,  8, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0,  8, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 12, 0, 0, 0, 0, 0, 2));
    for (int k = 0; k < 2; k++) begin
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8, 0, 0, 0, 0, 0, -1));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8, 0, 0, 0, 0, 0, -1));
    end

    do_reset();
    foreach (tbl[k]) begin
      zero_cnts();
      btns(tbl[k].m, tbl[k].i, tbl[k].c);
      hold(tbl[k].cyc);
      check($sformatf("seg%0d_mode", k), int'(bus.MODE), tbl[k].e_mode);
      check($sformatf("seg%0d_inc_hour", k), n_ih, tbl[k].e_ih);
      check($sformatf("seg%0d_inc_min", k), n_im, tbl[k].e_im);
      check($sformatf("seg%0d_inc_sec", k), n_is, tbl[k].e_is);
      check($sformatf("seg%0d_clr", k), n_clr, tbl[k].e_clr);
      if (tbl[k].e_en >= 0) check($sformatf("seg%0d_en_sec", k), n_en, tbl[k].e_en);
    end
    btns(1'b0, 1'b0, 1'b0);

    // Press latency from the first raw sample to the MODE update.
    do_reset();
    btns(1'b1, 1'b0, 1'b0);
    n = 0;
    while (bus.MODE == 2'd0 && n < 20) begin tick(); n++; end
    check("mode_latency", n, DB + 4);
    check("mode_after_press", int'(bus.MODE), 1);
    btns(1'b0, 1'b0, 1'b0);
    hold(10);

    // Glitch and bounce in SET_SEC.
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    check("mode_set_sec", int'(bus.MODE), 3);
    zero_cnts();
    btns(1'b0, 1'b1, 1'b0); hold(3);
    btns(1'b0, 1'b0, 1'b0); hold(10);
    check("glitch_inc_sec", n_is, 0);
    zero_cnts();
    btns(1'b0, 1'b1, 1'b0); hold(6);
    btns(1'b0, 1'b0, 1'b0); hold(2);
    btns(1'b0, 1'b1, 1'b0); hold(10);
    btns(1'b0, 1'b0, 1'b0); hold(10);
    check("bounce_inc_sec", n_is, 1);
    check("bounce_other_inc", n_ih + n_im, 0);

    // Back to RUN, then the first tick comes DIV cycles later.
    btns(1'b1, 1'b0, 1'b0);
    n = 0;
    while (bus.MODE != 2'd0 && n < 20) begin tick(); n++; end
    check("mode_to_run", int'(bus.MODE), 0);
    btns(1'b0, 1'b0, 1'b0);
    n = 0;
    do begin tick(); n++; end while (!bus.EN_SEC && n < 30);
    check("en_after_run", n, DIV);

    // Clear raised at prescaler count 6 restarts the second.
    n = 0;
    while ((run_cnt % DIV) != 6 && n < 30) begin tick(); n++; end
    btns(1'b0, 1'b0, 1'b1);
    n = 0;
    while (!bus.CLR && n < 20) begin tick(); n++; end
    check("clr_latency", n, DB + 4);
    btns(1'b0, 1'b0, 1'b0);
    n = 0;
    do begin tick(); n++; end while (!bus.EN_SEC && n < 30);
    check("en_after_clr", n, DIV);

    // CLR and INC together in SET_HOUR: clear wins.
    press(1'b1, 1'b0, 1'b0);
    zero_cnts();
    press(1'b0, 1'b1, 1'b1);
    check("clr_inc_clr", n_clr, 1);
    check("clr_inc_hour", n_ih, 0);
    check("clr_inc_mode", int'(bus.MODE), 1);

    // Reset in SET_MIN with INC held.
    press(1'b1, 1'b0, 1'b0);
    btns(1'b0, 1'b1, 1'b0);
    hold(10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mode", int'(bus.MODE), 0);
    check("rst_pulses", int'({bus.EN_SEC, bus.INC_SEC, bus.INC_MIN, bus.INC_HOUR, bus.CLR, bus.BLINK}), 0);
    zero_cnts();
    hold(16);
    check("rst_held_inc", n_ih + n_im + n_is, 0);
    check("rst_blink", int'(bus.BLINK), 0);
    check("rst_mode_after", int'(bus.MODE), 0);
    btns(1'b0, 1'b0, 1'b0);
    hold(10);

    // Randomized buttons and occasional reset.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end else begin
        btns(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
        hold(int'($urandom_range(1, 14)));
      end
    end
    btns(1'b0, 1'b0, 1'b0);
    hold(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
